// File: rtl/cbx_param_cfg.sv
// Parametrised horizontal connection block: straight-through tracks, per-pin muxes,
// and a shadowed config chain whose contents go live only after a length-checked commit.

module cbx_pin_mux #(
    parameter int MUX_SIZE = 4,
    parameter int SEL_W    = 2
) (
    input  logic [MUX_SIZE-1:0] mux_in,
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic                pin
);
    // Selects past the last input (non-power-of-2 sizes) drive 0.
    always_comb begin
        pin = 1'b0;
        if (en && (int'(sel) < MUX_SIZE))
            pin = mux_in[sel];
    end
endmodule

module cbx_param_cfg #(
    parameter int CHAN_W   = 10,
    parameter int NUM_IPIN = 8,
    parameter int MUX_SIZE = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    input  logic                ccff_head,
    input  logic                cfg_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic                cfg_done,
    output logic                cfg_err
);
    localparam int H         = MUX_SIZE / 2;
    localparam int STRIDE    = CHAN_W / H;
    localparam int SEL_W     = $clog2(MUX_SIZE);
    localparam int CHAIN_LEN = NUM_IPIN * SEL_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

    logic [CHAIN_LEN-1:0]               sr;
    logic [CHAIN_LEN-1:0]               active;
    logic [CNT_W-1:0]                   bit_cnt;
    logic [NUM_IPIN-1:0][MUX_SIZE-1:0]  mux_in;

    assign chanx_right_out = chanx_left_in;
    assign chanx_left_out  = chanx_right_in;
    assign ccff_tail       = sr[CHAIN_LEN-1];

    // Counter saturates one past CHAIN_LEN so an overrun can never alias a full load.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr       <= '0;
            active   <= '0;
            bit_cnt  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else if (cfg_en) begin
            sr <= (sr << 1) | CHAIN_LEN'(ccff_head);
            if (bit_cnt != CNT_W'(CHAIN_LEN + 1))
                bit_cnt <= bit_cnt + 1'b1;
            if (cfg_commit)
                cfg_err <= 1'b1;
        end else if (cfg_commit) begin
            bit_cnt <= '0;
            if (bit_cnt == CNT_W'(CHAIN_LEN)) begin
                active   <= sr;
                cfg_done <= 1'b1;
                cfg_err  <= 1'b0;
            end else begin
                cfg_err  <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
        for (genvar j = 0; j < H; j++) begin : g_trk
            localparam int T = (k + j * STRIDE) % CHAN_W;
            assign mux_in[k][2*j]   = chanx_left_in[T];
            assign mux_in[k][2*j+1] = chanx_right_in[T];
        end
        cbx_pin_mux #(.MUX_SIZE(MUX_SIZE), .SEL_W(SEL_W)) u_mux (
            .mux_in (mux_in[k]),
            .sel    (active[k*SEL_W +: SEL_W]),
            .en     (cfg_done),
            .pin    (ipin_out[k])
        );
    end
endmodule
